// File: rtl/mul_div_unit_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
package mul_div_unit_pkg;
  localparam int MD_XLEN = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } mdState_t;
endpackage

// File: rtl/mul_div_unit_lca.sv
// Look-ahead-carry adder: generate/propagate with a carry chain.
module lca_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  input  logic         iCin,
  output logic [W-1:0] oSum,
  output logic         oCout
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = iA & iB;
    p    = iA ^ iB;
    c    = '0;
    c[0] = iCin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign oSum  = p ^ c[W-1:0];
  assign oCout = c[W];
endmodule

// File: rtl/mul_div_unit_negate.sv
// Conditional two's-complement negate; oCarry is set when a negated input was 0.
module md_negate #(
  parameter int W = 32
) (
  input  logic         iEn,
  input  logic [W-1:0] iData,
  output logic [W-1:0] oData,
  output logic         oCarry
);
  lca_adder #(.W(W)) uLca (
    .iA   (iData ^ {W{iEn}}),
    .iB   ('0),
    .iCin (iEn),
    .oSum (oData),
    .oCout(oCarry)
  );
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = MD_XLEN
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [XLEN-1:0] iDataA,
  input  logic [XLEN-1:0] iDataB,
  input  logic [2:0]      iFunct3,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oData,
  output logic            oZero
);
  localparam logic [4:0] LAST = 5'(ITER - 1);

  mdState_t state, nextState;

  logic [XLEN-1:0]   aReg, bReg, dataReg;
  logic [2*XLEN-1:0] acc;
  logic [4:0]        cnt;
  logic [2:0]        op;
  logic              negA, negB, divZero;

  logic            isDiv, sA, sB, bZero, qBit;
  logic            negEn, negCarry;
  logic [XLEN-1:0] negIn, negOut;
  logic [XLEN-1:0] addA, addB, addSum;
  logic            addCin, addCout;
  logic [XLEN-1:0] result;

  assign isDiv = op[2];
  assign sA = (op == MD_MULH) | (op == MD_MULHSU) | (op == MD_DIV) | (op == MD_REM);
  assign sB = (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM);
  assign bZero = isDiv & (bReg == '0);
  // Bit dropped by the remainder shift makes the trial subtract non-negative.
  assign qBit = acc[2*XLEN-1] | addCout;

  md_negate #(.W(XLEN)) uNeg (
    .iEn   (negEn),
    .iData (negIn),
    .oData (negOut),
    .oCarry(negCarry)
  );

  lca_adder #(.W(XLEN)) uAdd (
    .iA   (addA),
    .iB   (addB),
    .iCin (addCin),
    .oSum (addSum),
    .oCout(addCout)
  );

  always_comb begin
    negEn  = 1'b0;
    negIn  = '0;
    addA   = '0;
    addB   = '0;
    addCin = 1'b0;
    result = '0;
    unique case (state)
      PREP: begin
        negEn  = sA & aReg[XLEN-1];
        negIn  = aReg;
        addA   = bReg ^ {XLEN{sB & bReg[XLEN-1]}};
        addCin = sB & bReg[XLEN-1];
      end
      CALC: begin
        // Counter increment as -(~cnt).
        negEn = 1'b1;
        negIn = ~XLEN'(cnt);
        if (isDiv) begin
          addA   = {acc[2*XLEN-2:XLEN], aReg[XLEN-1]};
          addB   = ~bReg;
          addCin = 1'b1;
        end else begin
          addA = acc[2*XLEN-1:XLEN];
          addB = bReg[0] ? aReg : '0;
        end
      end
      FIX: begin
        if (isDiv) begin
          negEn = op[1] ? negA : (negA ^ negB);
          negIn = op[1] ? acc[2*XLEN-1:XLEN] : aReg;
          if (divZero) result = op[1] ? aReg : '1;
          else result = negOut;
        end else begin
          negEn  = negA ^ negB;
          negIn  = acc[XLEN-1:0];
          addA   = acc[2*XLEN-1:XLEN] ^ {XLEN{negA ^ negB}};
          addCin = negCarry;
          result = (op == MD_MUL) ? negOut : addSum;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (iValid) nextState = PREP;
      PREP: nextState = bZero ? FIX : CALC;
      CALC: if (cnt == LAST) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else state <= nextState;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      aReg    <= '0;
      bReg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      op      <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      dataReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iValid) begin
            aReg <= iDataA;
            bReg <= iDataB;
            op   <= iFunct3;
          end
        end
        PREP: begin
          negA    <= sA & aReg[XLEN-1];
          negB    <= sB & bReg[XLEN-1];
          acc     <= '0;
          cnt     <= '0;
          divZero <= bZero;
          if (!bZero) begin
            aReg <= negOut;
            bReg <= addSum;
          end
        end
        CALC: begin
          cnt <= negOut[4:0];
          if (isDiv) begin
            acc[2*XLEN-1:XLEN] <= qBit ? addSum : addA;
            aReg <= {aReg[XLEN-2:0], qBit};
          end else begin
            acc  <= {addCout, addSum, acc[XLEN-1:1]};
            bReg <= {1'b0, bReg[XLEN-1:1]};
          end
        end
        FIX: dataReg <= result;
        default: ;
      endcase
    end
  end

  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);
  assign oData  = dataReg;
  assign oZero  = ~|dataReg;
endmodule
